tile_scheduler: RTL and testbench
=================================

# tile_scheduler

Game-sequencing controller for the piano-tiles design. Owns the falling-tile set (up to four slots across three lanes) and the IDLE/PLAY/OVER game state machine. Also owns score, lives and scroll speed. Sits between the keyboard decoder, the random lane source and the frame timing (upstream) and the pixel generator and score display (downstream), replacing ad-hoc state inside the pixel path.

## Interface
Parameters:
- NUM_SLOTS, 4: tile slots (ring order, oldest = head)
- SCREEN_H, 480: visible lines
- TILE_H, 120: tile height in lines; also minimum spawn gap
- HIT_Y, 360: top line of hit zone
- SPEED_INIT, 2: lines per frame at start
- SPEED_MAX, 8: speed ceiling
- LEVEL_STEP, 10: hits per speed increment
- LIVES_INIT, 3: lives at game start

Ports:
- clk  in  1  pixel-domain clock (the same divided clock as the VGA counters)
- rst  in  1  synchronous, active-high reset
- frame_tick  in  1  one-cycle pulse per frame (end of active video)
- key_lane  in  3  one-cycle press pulses, bit0=A, bit1=S, bit2=D
- key_start  in  1  one-cycle Enter pulse
- rand_lane  in  2  random lane; value 3 maps to lane 0
- tile_valid  out  NUM_SLOTS  slot occupied
- tile_lane  out  2*NUM_SLOTS  lane per slot
- tile_y  out  10*NUM_SLOTS  top line per slot
- score  out  10  hits, saturates at 999
- lives  out  2  remaining lives
- game_state  out  2  0=IDLE, 1=PLAY, 2=OVER
- hit_pulse  out  1  one cycle per correct press
- miss_pulse  out  1  one cycle per wrong press or tile lost

## Operation
- IDLE: slots empty. key_start → PLAY, with score=0, lives=LIVES_INIT, speed=SPEED_INIT, level counter=0 and all slots cleared.
- PLAY, on frame_tick:
  - Scroll: every valid slot gets y += speed.
  - Loss: a head tile whose post-scroll y ≥ SCREEN_H is invalidated; lives−1; miss_pulse.
  - Spawn: when a free slot exists and either no tile is valid or the newest tile has post-scroll y ≥ TILE_H, a new tile is placed at the tail with y=0 and lane=rand_lane.
- PLAY, key_lane ≠ 0. Only the head tile is judged, against its pre-tick y:
  - Hit: exactly one bit set, matching the head lane, and head y ≥ HIT_Y−TILE_H (bottom edge inside the hit zone). Head is invalidated; score+1 (saturating at 999); level counter+1; hit_pulse.
  - Level-up: when the level counter reaches LEVEL_STEP it clears and speed+1, capped at SPEED_MAX.
  - Any other press (multiple bits, wrong lane, out of zone, or no valid tile): lives−1; miss_pulse.
- Same cycle key and frame_tick: the key is judged first. If it hits, scroll/loss/spawn apply to the remaining slots. Both decrements may apply (−2). Lives floor at 0.
- Lives reaching 0 → OVER on the next cycle. Slots freeze and score holds.
- OVER: key_start → IDLE. Keys are ignored in IDLE and OVER; key_start is ignored in PLAY.

## Timing
- All outputs are registered. Reset values: game_state=IDLE, tile_valid=0, tile_lane=0, tile_y=0, score=0, lives=LIVES_INIT, pulses=0, speed=SPEED_INIT.
- An event in cycle N updates outputs at N+1. Pulses last exactly one cycle.
- IDLE→PLAY: first spawn occurs on the first frame_tick after entry.
- rst during PLAY overrides all activity in the same edge.
- tile_y never exceeds SCREEN_H+SPEED_MAX−1 before invalidation; 10-bit width suffices.

## Structure
- Shared package piano_pkg:
  - game_state encoding (IDLE/PLAY/OVER)
  - lane encoding
  - default SCREEN_H/TILE_H/HIT_Y constants
- Sub-module tile_ring: slot storage, head/tail pointers (wrap modulo NUM_SLOTS), push/pop/scroll. The FSM, scoring, speed and hit judging stay in tile_scheduler.

## Test plan
- Reset, key_start, 1 frame_tick with rand_lane=2 → state PLAY, tile_valid=0001, lane0=2, y0=0, lives=3, score=0.
- Tile in lane 1, y=250; key_lane=010 → hit_pulse 1 cycle, score=1, slot freed. Repeat at y=100 → miss_pulse, lives=2, tile kept.
- No presses, 240+ frames → first head tile y≥480 invalidated, lives decrement per lost tile, then OVER after third loss; key_start → IDLE.
- Ten consecutive hits → speed goes 2→3. Hits beyond (SPEED_MAX−SPEED_INIT)×10 keep speed at 8. Score at 999 stays 999 on further hits.
- key_lane=011 on an in-zone lane-0 head → miss_pulse, lives−1.
- Key and frame_tick in the same cycle with lives=1, wrong press, plus head tile lost → lives=0 (no underflow), OVER next cycle.

Source files
------------

// File: rtl/piano_pkg.sv
// Shared types and default geometry for the piano-tiles game path.
package piano_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StPlay = 2'd1,
        StOver = 2'd2
    } game_state_e;

    typedef enum logic [1:0] {
        LaneA = 2'd0,
        LaneS = 2'd1,
        LaneD = 2'd2
    } lane_e;

    localparam int unsigned ScreenHDefault = 480;
    localparam int unsigned TileHDefault   = 120;
    localparam int unsigned HitYDefault    = 360;

    // The random source yields 0..3 but there are only three lanes.
    function automatic logic [1:0] map_lane(input logic [1:0] raw);
        if (raw == 2'd3) begin
            return 2'(LaneA);
        end
        return raw;
    endfunction

endpackage

// File: rtl/tile_ring.sv
// Ring of falling-tile slots: pop at head, scroll, drop off-screen head, spawn at tail.
module tile_ring
    import piano_pkg::*;
#(
    parameter int unsigned NUM_SLOTS = 4,
    parameter int unsigned SCREEN_H  = ScreenHDefault,
    parameter int unsigned TILE_H    = TileHDefault
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     pop_i,
    input  logic                     scroll_i,
    input  logic [3:0]               speed_i,
    input  logic [1:0]               spawn_lane_i,
    output logic                     head_valid_o,
    output logic [1:0]               head_lane_o,
    output logic [9:0]               head_y_o,
    output logic                     lost_o,
    output logic [NUM_SLOTS-1:0]     valid_o,
    output logic [2*NUM_SLOTS-1:0]   lane_o,
    output logic [10*NUM_SLOTS-1:0]  y_o
);

    localparam int unsigned PtrW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    logic [NUM_SLOTS-1:0] valid_q, valid_d;
    logic [1:0]           lane_q [NUM_SLOTS];
    logic [1:0]           lane_d [NUM_SLOTS];
    logic [9:0]           y_q    [NUM_SLOTS];
    logic [9:0]           y_d    [NUM_SLOTS];
    logic [PtrW-1:0]      head_q, head_d, tail_q, tail_d;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (32'(p) == NUM_SLOTS - 1) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [PtrW-1:0] ptr_dec(input logic [PtrW-1:0] p);
        return (p == '0) ? PtrW'(NUM_SLOTS - 1) : p - 1'b1;
    endfunction

    // Pop (hit) is applied before scrolling so loss/spawn see the remaining slots.
    always_comb begin
        valid_d = valid_q;
        lane_d  = lane_q;
        y_d     = y_q;
        head_d  = head_q;
        tail_d  = tail_q;
        lost_o  = 1'b0;
        if (clear_i) begin
            valid_d = '0;
            head_d  = '0;
            tail_d  = '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                lane_d[i] = '0;
                y_d[i]    = '0;
            end
        end else begin
            if (pop_i && valid_q[head_q]) begin
                valid_d[head_q] = 1'b0;
                head_d          = ptr_inc(head_q);
            end
            if (scroll_i) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (valid_d[i]) begin
                        y_d[i] = y_q[i] + 10'(speed_i);
                    end
                end
                if (valid_d[head_d] && y_d[head_d] >= 10'(SCREEN_H)) begin
                    valid_d[head_d] = 1'b0;
                    head_d          = ptr_inc(head_d);
                    lost_o          = 1'b1;
                end
                // Slot at tail is free exactly when the ring is not full.
                if (!valid_d[tail_q] &&
                    (valid_d == '0 || y_d[ptr_dec(tail_q)] >= 10'(TILE_H))) begin
                    valid_d[tail_q] = 1'b1;
                    lane_d[tail_q]  = spawn_lane_i;
                    y_d[tail_q]     = '0;
                    tail_d          = ptr_inc(tail_q);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                lane_q[i] <= '0;
                y_q[i]    <= '0;
            end
        end else begin
            valid_q <= valid_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            lane_q  <= lane_d;
            y_q     <= y_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            lane_o[2*i +: 2]  = lane_q[i];
            y_o[10*i +: 10]   = y_q[i];
        end
    end

    assign valid_o      = valid_q;
    assign head_valid_o = valid_q[head_q];
    assign head_lane_o  = lane_q[head_q];
    assign head_y_o     = y_q[head_q];

endmodule

// File: rtl/tile_scheduler.sv
// Game sequencer: IDLE/PLAY/OVER FSM, hit judging, score, lives and scroll speed.
module tile_scheduler
    import piano_pkg::*;
#(
    parameter int unsigned NUM_SLOTS  = 4,
    parameter int unsigned SCREEN_H   = ScreenHDefault,
    parameter int unsigned TILE_H     = TileHDefault,
    parameter int unsigned HIT_Y      = HitYDefault,
    parameter int unsigned SPEED_INIT = 2,
    parameter int unsigned SPEED_MAX  = 8,
    parameter int unsigned LEVEL_STEP = 10,
    parameter int unsigned LIVES_INIT = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_tick,
    input  logic [2:0]               key_lane,
    input  logic                     key_start,
    input  logic [1:0]               rand_lane,
    output logic [NUM_SLOTS-1:0]     tile_valid,
    output logic [2*NUM_SLOTS-1:0]   tile_lane,
    output logic [10*NUM_SLOTS-1:0]  tile_y,
    output logic [9:0]               score,
    output logic [1:0]               lives,
    output logic [1:0]               game_state,
    output logic                     hit_pulse,
    output logic                     miss_pulse
);

    game_state_e state_q, state_d;
    logic [9:0]  score_q, score_d;
    logic [1:0]  lives_q, lives_d;
    logic [3:0]  speed_q, speed_d;
    logic [7:0]  level_q, level_d;
    logic        hit_q, hit_d, miss_q, miss_d;

    logic        play_active, hit_now, key_miss, ring_clear, ring_lost;
    logic        head_valid;
    logic [1:0]  head_lane, dec;
    logic [9:0]  head_y;

    // Lives already at zero freezes play for the cycle before OVER takes effect.
    assign play_active = (state_q == StPlay) && (lives_q != 2'd0);
    assign ring_clear  = key_start && (state_q != StPlay);

    tile_ring #(
        .NUM_SLOTS (NUM_SLOTS),
        .SCREEN_H  (SCREEN_H),
        .TILE_H    (TILE_H)
    ) u_ring (
        .clk_i        (clk),
        .rst_i        (rst),
        .clear_i      (ring_clear),
        .pop_i        (hit_now),
        .scroll_i     (play_active && frame_tick),
        .speed_i      (speed_q),
        .spawn_lane_i (map_lane(rand_lane)),
        .head_valid_o (head_valid),
        .head_lane_o  (head_lane),
        .head_y_o     (head_y),
        .lost_o       (ring_lost),
        .valid_o      (tile_valid),
        .lane_o       (tile_lane),
        .y_o          (tile_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (key_start) state_d = StPlay;
            StPlay:  if (lives_q == 2'd0) state_d = StOver;
            StOver:  if (key_start) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        score_d  = score_q;
        lives_d  = lives_q;
        speed_d  = speed_q;
        level_d  = level_q;
        hit_now  = play_active && $onehot(key_lane) && head_valid &&
                   (key_lane == (3'b001 << head_lane)) &&
                   (head_y >= 10'(HIT_Y - TILE_H));
        key_miss = play_active && (key_lane != 3'b000) && !hit_now;
        dec      = 2'(key_miss) + 2'(ring_lost);
        hit_d    = hit_now;
        miss_d   = key_miss || ring_lost;
        if (state_q == StIdle && key_start) begin
            score_d = '0;
            lives_d = 2'(LIVES_INIT);
            speed_d = 4'(SPEED_INIT);
            level_d = '0;
        end else begin
            if (hit_now) begin
                if (score_q < 10'd999) begin
                    score_d = score_q + 10'd1;
                end
                if (level_q == 8'(LEVEL_STEP - 1)) begin
                    level_d = '0;
                    if (speed_q < 4'(SPEED_MAX)) begin
                        speed_d = speed_q + 4'd1;
                    end
                end else begin
                    level_d = level_q + 8'd1;
                end
            end
            lives_d = (lives_q > dec) ? lives_q - dec : 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            score_q <= '0;
            lives_q <= 2'(LIVES_INIT);
            speed_q <= 4'(SPEED_INIT);
            level_q <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
        end else begin
            score_q <= score_d;
            lives_q <= lives_d;
            speed_q <= speed_d;
            level_q <= level_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
        end
    end

    assign score      = score_q;
    assign lives      = lives_q;
    assign game_state = state_q;
    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;

endmodule

// File: tb/tb_tile_scheduler.sv
// Scoreboard bench for tile_scheduler: expectations queued per driven cycle, popped after the edge.
module tb_tile_scheduler;

    localparam int NS = 4;

    logic          clk = 1'b0;
    logic          rst, frame_tick, key_start;
    logic [2:0]    key_lane;
    logic [1:0]    rand_lane;
    logic [NS-1:0] tile_valid;
    logic [2*NS-1:0]  tile_lane;
    logic [10*NS-1:0] tile_y;
    logic [9:0]    score;
    logic [1:0]    lives, game_state;
    logic          hit_pulse, miss_pulse;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string tag;
        int    score;
        int    lives;
        int    state;
        int    hit;
        int    miss;
    } exp_t;

    exp_t sb[$];

    tile_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .key_lane   (key_lane),
        .key_start  (key_start),
        .rand_lane  (rand_lane),
        .tile_valid (tile_valid),
        .tile_lane  (tile_lane),
        .tile_y     (tile_y),
        .score      (score),
        .lives      (lives),
        .game_state (game_state),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int y_of(input int s);
        return int'(tile_y[s*10 +: 10]);
    endfunction

    function automatic int lane_of(input int s);
        return int'(tile_lane[s*2 +: 2]);
    endfunction

    // One clock of stimulus; lives < 0 means don't-care.
    task automatic cyc(input string tag, input bit ft, input logic [2:0] k, input bit st,
                       input bit r, input bit chk, input int e_score, input int e_lives,
                       input int e_state, input int e_hit, input int e_miss);
        exp_t e;
        if (chk) begin
            e.tag = tag; e.score = e_score; e.lives = e_lives;
            e.state = e_state; e.hit = e_hit; e.miss = e_miss;
            sb.push_back(e);
        end
        frame_tick = ft; key_lane = k; key_start = st; rst = r;
        @(posedge clk); #1;
        frame_tick = 1'b0; key_lane = 3'b000; key_start = 1'b0; rst = 1'b0;
        if (chk) begin
            e = sb.pop_front();
            check_val({e.tag, "/score"}, int'(score), e.score);
            if (e.lives >= 0) check_val({e.tag, "/lives"}, int'(lives), e.lives);
            check_val({e.tag, "/state"}, int'(game_state), e.state);
            check_val({e.tag, "/hit"}, int'(hit_pulse), e.hit);
            check_val({e.tag, "/miss"}, int'(miss_pulse), e.miss);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) cyc("tick", 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
    endtask

    task automatic wait_zone(input int h, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (tile_valid[h] && y_of(h) >= 240) begin
                ok = 1'b1;
                break;
            end
            cyc("tick", 1'b1, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
        end
        if (!ok) check_val("zone_timeout", 0, 1);
    endtask

    initial begin
        int  m_lives, m_score, h, yb, spd;
        bit  lost, press, ok;

        rst = 1'b1; frame_tick = 1'b0; key_lane = 3'b000; key_start = 1'b0; rand_lane = 2'd2;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check_val("rst_state", int'(game_state), 0);
        check_val("rst_valid", int'(tile_valid), 0);
        check_val("rst_lane", int'(tile_lane), 0);
        check_val("rst_y", (tile_y == '0) ? 1 : 0, 1);
        check_val("rst_score", int'(score), 0);
        check_val("rst_lives", int'(lives), 3);
        check_val("rst_hit", int'(hit_pulse), 0);
        check_val("rst_miss", int'(miss_pulse), 0);

        // Entry, ignored start in PLAY, first spawn.
        cyc("start", 0, 3'b000, 1, 0, 1, 0, 3, 1, 0, 0);
        check_val("start_valid", int'(tile_valid), 0);
        cyc("start_in_play", 0, 3'b000, 1, 0, 1, 0, 3, 1, 0, 0);
        cyc("first_tick", 1, 3'b000, 0, 0, 1, 0, 3, 1, 0, 0);
        check_val("first_valid", int'(tile_valid), 1);
        check_val("first_lane", lane_of(0), 2);
        check_val("first_y", y_of(0), 0);
        cyc("rst_busy", 1, 3'b001, 0, 1, 1, 0, 3, 0, 0, 0);
        check_val("rst_busy_valid", int'(tile_valid), 0);

        // Lane-1 tile: out-of-zone miss at y=100, hit at y=250.
        cyc("start2", 0, 3'b000, 1, 0, 1, 0, 3, 1, 0, 0);
        rand_lane = 2'd1;
        tick_n(51);
        check_val("y100", y_of(0), 100);
        check_val("lane1", lane_of(0), 1);
        cyc("press_low", 0, 3'b010, 0, 0, 1, 0, 2, 1, 0, 1);
        check_val("kept_after_miss", int'(tile_valid[0]), 1);
        cyc("after_miss", 0, 3'b000, 0, 0, 1, 0, 2, 1, 0, 0);
        tick_n(75);
        check_val("y250", y_of(0), 250);
        cyc("press_hit", 0, 3'b010, 0, 0, 1, 1, 2, 1, 1, 0);
        check_val("valid_after_hit", int'(tile_valid), 4'b0110);
        check_val("next_head_y", y_of(1), 130);
        cyc("after_hit", 0, 3'b000, 0, 0, 1, 1, 2, 1, 0, 0);

        // Unattended run: losses at ticks 241/301/361, last one with a wrong press too.
        cyc("rst3", 0, 3'b000, 0, 1, 1, 0, 3, 0, 0, 0);
        cyc("start3", 0, 3'b000, 1, 0, 1, 0, 3, 1, 0, 0);
        rand_lane = 2'd3;
        m_lives = 3;
        for (int k = 1; k <= 361; k++) begin
            lost  = (k >= 241) && ((k - 241) % 60 == 0);
            press = (k == 361);
            m_lives = m_lives - int'(lost) - int'(press);
            if (m_lives < 0) m_lives = 0;
            cyc("lose_run", 1, press ? 3'b100 : 3'b000, 0, 0, 1, 0, m_lives, 1, 0,
                int'(lost || press));
            if (k == 1) check_val("lane3_maps_0", lane_of(0), 0);
            if (k == 240) check_val("y_before_loss", y_of(0), 478);
            if (k == 241) begin
                check_val("wrap_valid", int'(tile_valid), 4'b1111);
                check_val("wrap_y", y_of(0), 0);
            end
        end
        cyc("over", 0, 3'b000, 0, 0, 1, 0, 0, 2, 0, 0);
        cyc("over_tick", 1, 3'b001, 0, 0, 1, 0, 0, 2, 0, 0);
        check_val("freeze_y0", y_of(0), 240);
        check_val("freeze_y3", y_of(3), 360);
        check_val("freeze_valid", int'(tile_valid), 4'b1111);
        cyc("over_start", 0, 3'b000, 1, 0, 1, 0, -1, 0, 0, 0);
        check_val("idle_valid", int'(tile_valid), 0);
        cyc("idle_keys", 1, 3'b010, 0, 0, 1, 0, -1, 0, 0, 0);
        check_val("idle_no_spawn", int'(tile_valid), 0);

        // Long hit run: boundary, double key, speed ladder, score saturation.
        cyc("rst4", 0, 3'b000, 0, 1, 1, 0, 3, 0, 0, 0);
        cyc("start4", 0, 3'b000, 1, 0, 1, 0, 3, 1, 0, 0);
        rand_lane = 2'd0;
        cyc("no_tile_press", 0, 3'b001, 0, 0, 1, 0, 2, 1, 0, 1);
        h = 0;
        m_score = 0;
        wait_zone(h, ok);
        if (ok) begin
            check_val("zone_edge_y", y_of(0), 240);
            cyc("double_key", 0, 3'b011, 0, 0, 1, 0, 1, 1, 0, 1);
            check_val("double_kept", int'(tile_valid[0]), 1);
            for (int n = 1; n <= 1000; n++) begin
                wait_zone(h, ok);
                if (!ok) break;
                m_score = (m_score < 999) ? m_score + 1 : 999;
                cyc("hit", 0, 3'b001, 0, 0, 1, m_score, 1, 1, 1, 0);
                h = (h + 1) % NS;
                if (n == 1) cyc("hit_once", 0, 3'b000, 0, 0, 1, 1, 1, 1, 0, 0);
                if (n == 9 || n == 10 || n == 60 || n == 70) begin
                    spd = 2 + n / 10;
                    if (spd > 8) spd = 8;
                    yb = y_of(h);
                    cyc("tick", 1, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
                    check_val($sformatf("speed_after_%0d", n), y_of(h) - yb, spd);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
